// File: rtl/multiplier_pipe_reg_pkg.sv
// Shared definitions for the pipelined multiplier: default geometry and the
// operand-extension helper used ahead of the multiply.
`ifndef MULTIPLIER_PIPE_REG_PKG_SV
`define MULTIPLIER_PIPE_REG_PKG_SV

package multiplier_pipe_reg_pkg;

    // Default operand width; the product is twice this wide.
    localparam int MUL_PIPE_DEF_W     = 32;

    // Default number of register stages between the operands and oData.
    localparam int MUL_PIPE_DEF_DEPTH = 3;

    // Bit used to widen an operand. Signed operands replicate their MSB and
    // unsigned operands pad with zero. This keeps the widened product exact
    // in both modes.
    function automatic logic extBit(input logic isSigned, input logic msb);
        return isSigned & msb;
    endfunction

endpackage

`endif

// File: rtl/multiplier_pipe_reg_if.sv
// Operand/result bundle between operand-fetch logic and the pipelined
// multiplier, including the pipeline controls that travel with the request.
interface multiplier_pipe_reg_if
    import multiplier_pipe_reg_pkg::*;
#(
    parameter int DATA_W = MUL_PIPE_DEF_W
);

    logic                  iEn;
    logic                  iClr;
    logic                  iValid;
    logic                  iSigned;
    logic [DATA_W-1:0]     iData0;
    logic [DATA_W-1:0]     iData1;
    logic                  oValid;
    logic [2*DATA_W-1:0]   oData;

    // Producer side: issues operations and observes completed products.
    modport master (
        output iEn, iClr, iValid, iSigned, iData0, iData1,
        input  oValid, oData
    );

    // Multiplier side.
    modport slave (
        input  iEn, iClr, iValid, iSigned, iData0, iData1,
        output oValid, oData
    );

endinterface

// File: rtl/multiplier_pipe_reg_stage.sv
// One pipeline stage: a valid bit plus a payload register. The payload only
// loads behind a real operation, so bubbles never disturb the last product.
module mul_pipe_stage #(
    parameter int W = 64
) (
    input  logic         iClk,
    input  logic         iRstN,
    input  logic         iClr,
    input  logic         iEn,
    input  logic         iValid,
    input  logic [W-1:0] iData,
    output logic         oValid,
    output logic [W-1:0] oData
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Reset and flush wipe the stage; otherwise advance on enable, else hold.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (iClr) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (iEn) begin
            r_valid <= iValid;
            if (iValid) begin
                r_data <= iData;
            end
        end
    end

    assign oValid = r_valid;
    assign oData  = r_data;

endmodule

// File: rtl/multiplier_pipe_reg.sv
// Pipelined signed/unsigned multiplier. The product is formed combinationally
// ahead of the first stage and then carried through PIPE valid-tagged stages.
// All of the registers sit behind the multiplier, so retiming can pull them
// into it.
module multiplier_pipe_reg
    import multiplier_pipe_reg_pkg::*;
#(
    parameter int DATA_W = MUL_PIPE_DEF_W,
    parameter int PIPE   = MUL_PIPE_DEF_DEPTH
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    multiplier_pipe_reg_if.slave  bus
);

    localparam int PW = 2 * DATA_W;

    logic          w_ext0;
    logic          w_ext1;
    logic [PW-1:0] w_opA;
    logic [PW-1:0] w_opB;
    logic [PW-1:0] w_product;
    logic [PIPE:0] w_valid;
    logic [PW-1:0] w_data [0:PIPE];

    // Widen both operands to the full product width. The 2*DATA_W result
    // matches the exact (DATA_W+1)-bit extended multiply in both modes.
    assign w_ext0    = extBit(bus.iSigned, bus.iData0[DATA_W-1]);
    assign w_ext1    = extBit(bus.iSigned, bus.iData1[DATA_W-1]);
    assign w_opA     = {{DATA_W{w_ext0}}, bus.iData0};
    assign w_opB     = {{DATA_W{w_ext1}}, bus.iData1};
    assign w_product = w_opA * w_opB;

    assign w_valid[0] = bus.iValid;
    assign w_data[0]  = w_product;

    // Chain of identical stages; stage k feeds stage k+1.
    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        mul_pipe_stage #(
            .W (PW)
        ) u_stage (
            .iClk   (iClk),
            .iRstN  (iRstN),
            .iClr   (bus.iClr),
            .iEn    (bus.iEn),
            .iValid (w_valid[k]),
            .iData  (w_data[k]),
            .oValid (w_valid[k+1]),
            .oData  (w_data[k+1])
        );
    end

    assign bus.oValid = w_valid[PIPE];
    assign bus.oData  = w_data[PIPE];

endmodule

// File: tb/tb_multiplier_pipe_reg.sv
// Bench for multiplier_pipe_reg: a 32-bit/3-stage instance with a scoreboard,
// plus 32-bit/1-stage and 8-bit/5-stage instances for latency corners.
module tb_multiplier_pipe_reg;

    localparam int W0 = 32;
    localparam int P0 = 3;
    localparam int W1 = 32;
    localparam int P1 = 1;
    localparam int W2 = 8;
    localparam int P2 = 5;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    multiplier_pipe_reg_if #(.DATA_W(W0)) bus0();
    multiplier_pipe_reg_if #(.DATA_W(W1)) bus1();
    multiplier_pipe_reg_if #(.DATA_W(W2)) bus2();

    multiplier_pipe_reg #(.DATA_W(W0), .PIPE(P0)) dut0 (.iClk(clk), .iRstN(rstN), .bus(bus0));
    multiplier_pipe_reg #(.DATA_W(W1), .PIPE(P1)) dut1 (.iClk(clk), .iRstN(rstN), .bus(bus1));
    multiplier_pipe_reg #(.DATA_W(W2), .PIPE(P2)) dut2 (.iClk(clk), .iRstN(rstN), .bus(bus2));

    always #5 clk = ~clk;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [63:0] expQ [$];
    logic [63:0] lastExp     = '0;
    bit          lastAdv     = 1'b0;
    bit          monOn       = 1'b0;

    logic [31:0] cornerA   [3] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] cornerB   [3] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000002};
    logic [63:0] cornerExp [3] = '{64'h0000000000000001, 64'h4000000000000000, 64'hFFFFFFFFFFFFFFFE};

    // Reference product computed with native 64-bit integer arithmetic
    function automatic logic [63:0] refMul32(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return sa * sb;
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Remember whether the last rising edge actually advanced the main pipeline
    always @(posedge clk) lastAdv = rstN && bus0.iEn && !bus0.iClr;

    // Scoreboard: each newly completed result must match the oldest outstanding issue
    always @(negedge clk) begin
        if (monOn && lastAdv && bus0.oValid === 1'b1) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL scoreboard_unexpected: got oData=%h, required no result", bus0.oData);
            end else begin
                logic [63:0] exp;
                exp = expQ.pop_front();
                if (bus0.oData !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL scoreboard_data: got %h, required %h", bus0.oData, exp);
                end
            end
        end
    end

    // Drive one cycle on the main instance (called and returning on a falling edge)
    task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [31:0] b, input bit s);
        bus0.iValid  = v;
        bus0.iData0  = a;
        bus0.iData1  = b;
        bus0.iSigned = s;
        if (v) begin
            lastExp = refMul32(a, b, s);
            expQ.push_back(lastExp);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        testsRun++;
        if (bus0.oValid !== 1'b0 || bus0.oData !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_dut0: got v=%b d=%h, required v=0 d=0", bus0.oValid, bus0.oData);
        end
        testsRun++;
        if (bus1.oValid !== 1'b0 || bus1.oData !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_dut1: got v=%b d=%h, required v=0 d=0", bus1.oValid, bus1.oData);
        end
        testsRun++;
        if (bus2.oValid !== 1'b0 || bus2.oData !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_dut2: got v=%b d=%h, required v=0 d=0", bus2.oValid, bus2.oData);
        end
        rstN  = 1'b1;
        monOn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_max();
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        for (int k = 1; k < P0; k++) begin
            testsRun++;
            if (bus0.oValid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL umax_early_valid: got %b at cycle %0d, required 0", bus0.oValid, k);
            end
            idle(1);
        end
        testsRun++;
        if (bus0.oValid !== 1'b1 || bus0.oData !== 64'hFFFFFFFE00000001) begin
            testsFailed++;
            $display("[TB] FAIL umax_result: got v=%b d=%h, required v=1 d=fffffffe00000001", bus0.oValid, bus0.oData);
        end
        idle(2);
    endtask

    task automatic test_signed_corners();
        for (int t = 0; t < 3 + P0; t++) begin
            if (t < 3) applyStimulus(1'b1, cornerA[t], cornerB[t], 1'b1);
            else       idle(1);
            if (t >= P0 - 1 && t <= P0 + 1) begin
                testsRun++;
                if (bus0.oValid !== 1'b1 || bus0.oData !== cornerExp[t-P0+1]) begin
                    testsFailed++;
                    $display("[TB] FAIL signed_corner%0d: got v=%b d=%h, required v=1 d=%h",
                             t - P0 + 1, bus0.oValid, bus0.oData, cornerExp[t-P0+1]);
                end
            end
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t <= 8 + P0; t++) begin
            if (t < 8) applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            else       idle(1);
            testsRun++;
            if (bus0.oValid !== ((t >= P0 - 1 && t <= P0 + 6) ? 1'b1 : 1'b0)) begin
                testsFailed++;
                $display("[TB] FAIL b2b_valid: got %b at cycle %0d", bus0.oValid, t);
            end
        end
        testsRun++;
        if (bus0.oData !== lastExp || expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_hold: got d=%h pending=%0d, required d=%h pending=0",
                     bus0.oData, expQ.size(), lastExp);
        end
    endtask

    task automatic test_stall();
        logic        holdV;
        logic [63:0] holdD;
        for (int t = 0; t < 3; t++) applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
        holdV = bus0.oValid;
        holdD = bus0.oData;
        bus0.iEn    = 1'b0;
        bus0.iValid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            testsRun++;
            if (bus0.oValid !== holdV || bus0.oData !== holdD) begin
                testsFailed++;
                $display("[TB] FAIL stall_frozen: got v=%b d=%h, required v=%b d=%h",
                         bus0.oValid, bus0.oData, holdV, holdD);
            end
        end
        bus0.iEn = 1'b1;
        for (int t = 3; t <= P0 + 2; t++) begin
            idle(1);
            testsRun++;
            if (bus0.oValid !== ((t >= P0 - 1 && t <= P0 + 1) ? 1'b1 : 1'b0)) begin
                testsFailed++;
                $display("[TB] FAIL stall_timing: got v=%b at cycle %0d", bus0.oValid, t + 4);
            end
        end
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL stall_lost: got %0d pending results, required 0", expQ.size());
        end
    endtask

    task automatic test_clear();
        for (int r = 0; r < 2; r++) begin
            for (int t = 0; t < 2; t++) applyStimulus(1'b1, $urandom | 32'h1, $urandom | 32'h1, 1'b0);
            bus0.iClr   = 1'b1;
            bus0.iEn    = (r == 0);
            bus0.iValid = 1'b1;
            bus0.iData0 = 32'h12345678;
            bus0.iData1 = 32'h9;
            expQ.delete();
            @(negedge clk);
            testsRun++;
            if (bus0.oValid !== 1'b0 || bus0.oData !== 64'd0) begin
                testsFailed++;
                $display("[TB] FAIL clear_outputs(en=%0d): got v=%b d=%h, required v=0 d=0",
                         bus0.iEn, bus0.oValid, bus0.oData);
            end
            bus0.iClr = 1'b0;
            bus0.iEn  = 1'b1;
            applyStimulus(1'b1, 32'hFFFFFFF9, 32'h00000003, 1'b1);
            idle(P0 - 1);
            testsRun++;
            if (bus0.oValid !== 1'b1 || bus0.oData !== 64'hFFFFFFFFFFFFFFEB) begin
                testsFailed++;
                $display("[TB] FAIL clear_after: got v=%b d=%h, required v=1 d=ffffffffffffffeb",
                         bus0.oValid, bus0.oData);
            end
            idle(P0 + 1);
            testsRun++;
            if (expQ.size() != 0 || bus0.oValid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL clear_drain: got pending=%0d v=%b, required pending=0 v=0",
                         expQ.size(), bus0.oValid);
            end
        end
    endtask

    task automatic test_latency_pipe1();
        bus1.iValid  = 1'b1;
        bus1.iSigned = 1'b1;
        bus1.iData0  = 32'hFFFFFFF9;
        bus1.iData1  = 32'h00000009;
        @(negedge clk);
        testsRun++;
        if (bus1.oValid !== 1'b1 || bus1.oData !== 64'hFFFFFFFFFFFFFFC1) begin
            testsFailed++;
            $display("[TB] FAIL pipe1_signed: got v=%b d=%h, required v=1 d=ffffffffffffffc1", bus1.oValid, bus1.oData);
        end
        bus1.iSigned = 1'b0;
        bus1.iData0  = 32'hFFFFFFFF;
        bus1.iData1  = 32'h00000002;
        @(negedge clk);
        testsRun++;
        if (bus1.oValid !== 1'b1 || bus1.oData !== 64'h00000001FFFFFFFE) begin
            testsFailed++;
            $display("[TB] FAIL pipe1_unsigned: got v=%b d=%h, required v=1 d=00000001fffffffe", bus1.oValid, bus1.oData);
        end
        bus1.iValid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (bus1.oValid !== 1'b0 || bus1.oData !== 64'h00000001FFFFFFFE) begin
            testsFailed++;
            $display("[TB] FAIL pipe1_hold: got v=%b d=%h, required v=0 d=00000001fffffffe", bus1.oValid, bus1.oData);
        end
    endtask

    task automatic test_latency_w8();
        for (int t = 0; t < P2 + 2; t++) begin
            bus2.iValid  = (t < 2);
            bus2.iSigned = (t == 0);
            bus2.iData0  = (t == 0) ? 8'hFD : 8'hFF;
            bus2.iData1  = (t == 0) ? 8'h05 : 8'hFF;
            @(negedge clk);
            testsRun++;
            if (bus2.oValid !== ((t == P2 - 1 || t == P2) ? 1'b1 : 1'b0)) begin
                testsFailed++;
                $display("[TB] FAIL w8_valid: got %b at cycle %0d", bus2.oValid, t);
            end
            if (t == P2 - 1) begin
                testsRun++;
                if (bus2.oData !== 16'hFFF1) begin
                    testsFailed++;
                    $display("[TB] FAIL w8_signed: got %h, required fff1", bus2.oData);
                end
            end
            if (t >= P2) begin
                testsRun++;
                if (bus2.oData !== 16'hFE01) begin
                    testsFailed++;
                    $display("[TB] FAIL w8_unsigned: got %h at cycle %0d, required fe01", bus2.oData, t);
                end
            end
        end
    endtask

    task automatic test_reset_async();
        for (int t = 0; t < 2; t++) applyStimulus(1'b1, $urandom, $urandom, 1'b0);
        #2;
        rstN = 1'b0;
        expQ.delete();
        #1;
        testsRun++;
        if (bus0.oValid !== 1'b0 || bus0.oData !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_dut0: got v=%b d=%h, required v=0 d=0", bus0.oValid, bus0.oData);
        end
        testsRun++;
        if (bus2.oData !== 16'd0 || bus1.oData !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_others: got d1=%h d2=%h, required 0", bus1.oData, bus2.oData);
        end
        bus0.iValid = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        idle(P0 + 1);
        testsRun++;
        if (bus0.oValid !== 1'b0 || expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_flushed: got v=%b pending=%0d, required v=0 pending=0",
                     bus0.oValid, expQ.size());
        end
        applyStimulus(1'b1, 32'h0000FFFF, 32'h00010001, 1'b0);
        idle(P0 - 1);
        testsRun++;
        if (bus0.oValid !== 1'b1 || bus0.oData !== 64'h00000000FFFFFFFF) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_fresh: got v=%b d=%h, required v=1 d=00000000ffffffff",
                     bus0.oValid, bus0.oData);
        end
        idle(2);
    endtask

    initial begin
        bus0.iEn = 1'b1; bus0.iClr = 1'b0; bus0.iValid = 1'b0; bus0.iSigned = 1'b0; bus0.iData0 = '0; bus0.iData1 = '0;
        bus1.iEn = 1'b1; bus1.iClr = 1'b0; bus1.iValid = 1'b0; bus1.iSigned = 1'b0; bus1.iData0 = '0; bus1.iData1 = '0;
        bus2.iEn = 1'b1; bus2.iClr = 1'b0; bus2.iValid = 1'b0; bus2.iSigned = 1'b0; bus2.iData0 = '0; bus2.iData1 = '0;

        test_reset();
        test_unsigned_max();
        test_signed_corners();
        test_back_to_back();
        test_stall();
        test_clear();
        test_latency_pipe1();
        test_latency_w8();
        test_reset_async();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
